// File: rtl/parity_stream_gen_chk.sv
// Pipelined even/odd parity generator/checker on a valid/ready stream with frame parity.
// Optional saturating error counter and err_cnt port are compiled in with PARITY_ERR_CNT_EN.
module parity_stream_gen_chk #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic              odd_sel,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_par,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_par,
   output logic              out_err,
   output logic              out_last,
   output logic              out_frame_par,
   input  logic              cnt_clr
`ifdef PARITY_ERR_CNT_EN
  ,output logic [CNT_W-1:0]  err_cnt
`endif
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              par;
      logic              err;
      logic              last;
      logic              fpar;
   } beat_t;

   beat_t beat_q, beat_d;
   logic  vld_q;
   logic  facc_q, facc_d;
   logic  raw;
   logic  acc;

   assign in_ready = !vld_q || out_ready;
   assign acc      = in_valid && in_ready;
   assign raw      = ^in_data;

   always_comb begin
      beat_d.data = in_data;
      beat_d.par  = mode ? in_par : (raw ^ odd_sel);
      beat_d.err  = mode & (raw ^ in_par ^ odd_sel);
      beat_d.last = in_last;
      beat_d.fpar = in_last & (facc_q ^ raw ^ odd_sel);
      facc_d      = in_last ? 1'b0 : (facc_q ^ raw);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         beat_q <= '0;
         facc_q <= 1'b0;
      end else if (acc) begin
         vld_q  <= 1'b1;
         beat_q <= beat_d;
         facc_q <= facc_d;
      end else if (out_ready) begin
         vld_q  <= 1'b0;
      end
   end

   assign out_valid     = vld_q;
   assign out_data      = beat_q.data;
   assign out_par       = beat_q.par;
   assign out_err       = beat_q.err;
   assign out_last      = beat_q.last;
   // Frame parity is forced low unless a valid last beat is presented.
   assign out_frame_par = vld_q & beat_q.last & beat_q.fpar;

`ifdef PARITY_ERR_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (acc && beat_d.err && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign err_cnt = cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_parity_stream_gen_chk.sv
// Scoreboard bench for parity_stream_gen_chk: expected beats are queued on accept and
// compared while presented; the counter is modelled when PARITY_ERR_CNT_EN is defined.
module tb_parity_stream_gen_chk;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              mode, odd_sel, in_valid, in_ready, in_par, in_last;
   logic [DATA_W-1:0] in_data;
   logic              out_valid, out_ready, out_par, out_err, out_last, out_frame_par;
   logic [DATA_W-1:0] out_data;
   logic              cnt_clr;
`ifdef PARITY_ERR_CNT_EN
   logic [CNT_W-1:0]  err_cnt;
`endif

   parity_stream_gen_chk #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .odd_sel(odd_sel),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_par(in_par), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_par(out_par), .out_err(out_err), .out_last(out_last),
      .out_frame_par(out_frame_par), .cnt_clr(cnt_clr)
`ifdef PARITY_ERR_CNT_EN
     ,.err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic p, e, l, f;
   } exp_t;

   exp_t             q[$];
   logic             facc_m;
   logic [CNT_W-1:0] cnt_m;
   int               n_chk  = 0;
   int               n_fail = 0;

   // Fields of the most recently popped beat, for targeted checks.
   logic [DATA_W-1:0] obs_d;
   logic              obs_p, obs_e, obs_f;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic p, input logic l,
                       input logic md, input logic od, input logic ordy, input logic clr);
      exp_t e;
      logic raw, acc;
      @(negedge clk);
      in_valid = v; in_data = d; in_par = p; in_last = l;
      mode = md; odd_sel = od; out_ready = ordy; cnt_clr = clr;
      #1;
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, (q.size() == 0) || ordy);
      if (q.size() != 0) begin
         e = q[0];
         chk("out_data", out_data, e.d);
         chk("out_par", out_par, e.p);
         chk("out_err", out_err, e.e);
         chk("out_last", out_last, e.l);
         chk("out_frame_par", out_frame_par, e.f);
         if (ordy) begin
            obs_d = out_data; obs_p = out_par; obs_e = out_err; obs_f = out_frame_par;
            void'(q.pop_front());
         end
      end else begin
         chk("idle_frame_par", out_frame_par, 1'b0);
      end
`ifdef PARITY_ERR_CNT_EN
      chk("err_cnt", err_cnt, cnt_m);
`endif
      acc = v && ((q.size() == 0) || ordy || (ordy && q.size() == 0));
      raw = ^d;
      if (v && in_ready) begin
         e.d = d;
         e.p = md ? p : (raw ^ od);
         e.e = md ? (raw ^ p ^ od) : 1'b0;
         e.l = l;
         e.f = l ? (facc_m ^ raw ^ od) : 1'b0;
         facc_m = l ? 1'b0 : (facc_m ^ raw);
         q.push_back(e);
      end
      if (clr) cnt_m = '0;
      else if (v && in_ready && e.e && cnt_m != {CNT_W{1'b1}}) cnt_m = cnt_m + CNT_W'(1);
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, out_valid, 1'b0);
      chk({tag, "_data"}, out_data, '0);
      chk({tag, "_par"}, out_par, 1'b0);
      chk({tag, "_err"}, out_err, 1'b0);
      chk({tag, "_last"}, out_last, 1'b0);
      chk({tag, "_fpar"}, out_frame_par, 1'b0);
`ifdef PARITY_ERR_CNT_EN
      chk({tag, "_cnt"}, err_cnt, '0);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0; cnt_clr = 1'b0;
      #1;
      chk_reset_outputs("rst");
      q.delete();
      facc_m = 1'b0;
      cnt_m  = '0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; mode = 1'b0; odd_sel = 1'b0; in_valid = 1'b0; in_data = '0;
      in_par = 1'b0; in_last = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      facc_m = 1'b0; cnt_m = '0;
      obs_d = '0; obs_p = 1'b0; obs_e = 1'b0; obs_f = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      // Generate mode, even then odd.
      step(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("tp_gen_even_data", obs_d, 8'hA5);
      chk("tp_gen_even_par", obs_p, 1'b0);
      idle();
      chk("tp_gen_odd_par", obs_p, 1'b1);

      // Check mode, even parity: error then clean beat.
      step(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("tp_chk_err", obs_e, 1'b1);
`ifdef PARITY_ERR_CNT_EN
      chk("tp_cnt_1", err_cnt, 2'd1);
`endif
      idle();
      chk("tp_chk_ok", obs_e, 1'b0);
`ifdef PARITY_ERR_CNT_EN
      chk("tp_cnt_hold", err_cnt, 2'd1);
`endif

      // Frame parity: 3-beat frame then single-beat frame.
      step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("tp_frame3", obs_f, 1'b0);
      idle();
      chk("tp_frame1", obs_f, 1'b1);

      // Back-pressure with sustained valid, then release.
      for (int i = 0; i < 4; i++)
         step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 4; i < 8; i++)
         step(1'b1, 8'(8'h10 + i), 1'b0, (i == 7), 1'b0, 1'b0, 1'b1, 1'b0);
      idle();
      idle();

      // Saturation with a 2-bit counter, then clear colliding with an error beat.
      do_reset();
      for (int i = 0; i < 5; i++)
         step(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef PARITY_ERR_CNT_EN
      chk("tp_cnt_sat", err_cnt, 2'd3);
`endif
      idle();
`ifdef PARITY_ERR_CNT_EN
      chk("tp_cnt_clr", err_cnt, 2'd0);
`endif

      // Reset in mid-frame, then a fresh single-beat frame.
      step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      do_reset();
      step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      idle();
      chk("tp_post_rst_frame", obs_f, 1'b0);

      // Randomised traffic against the model.
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
              1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));

      for (int i = 0; i < 10 && q.size() != 0; i++) idle();
      chk("drain_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/parity_stream_gen_chk.md
# parity_stream_gen_chk

Parametrised, pipelined parity unit for the byte/word datapath: it generates or checks even/odd parity per beat on a valid/ready stream, accumulates a running parity across each frame (delimited by `in_last`), and counts check failures. It sits between a stream source and a serialiser or link, replacing the single-byte combinational even-parity generator wherever back-pressure, odd parity or frame-level parity is needed.

## Interface
Parameters:
- `DATA_W`, default 8: data beat width in bits, must be ≥ 1.
- `CNT_W`, default 16: error counter width in bits, must be ≥ 1.

Ports:
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: reset, asynchronous assert, active-low.
- `mode` input, 1 bit: 0 = generate, 1 = check. Sampled per accepted beat.
- `odd_sel` input, 1 bit: 0 = even parity, 1 = odd parity. Sampled per accepted beat.
- `in_valid` input, 1 bit: input beat valid.
- `in_ready` output, 1 bit: input beat accepted when `in_valid && in_ready`.
- `in_data` input, `DATA_W` bits: data beat.
- `in_par` input, 1 bit: received parity bit. Used in check mode only.
- `in_last` input, 1 bit: final beat of the frame.
- `out_valid` output, 1 bit: output beat valid.
- `out_ready` input, 1 bit: downstream accept.
- `out_data` output, `DATA_W` bits: registered copy of `in_data`.
- `out_par` output, 1 bit: generated parity in generate mode; `in_par` passed through in check mode.
- `out_err` output, 1 bit: parity mismatch on this beat. Always 0 in generate mode.
- `out_last` output, 1 bit: registered copy of `in_last`.
- `out_frame_par` output, 1 bit: frame parity. Meaningful only when `out_valid && out_last`, otherwise 0.
- `cnt_clr` input, 1 bit: synchronous clear of the error counter.
- `err_cnt` output, `CNT_W` bits: saturating error count. Present only with `PARITY_ERR_CNT_EN`.

## Operation
- Accept is `acc = in_valid && in_ready`. The raw parity of a beat is `raw = ^in_data`.
- Generate mode: `out_par = raw ^ odd_sel` and `out_err = 0`.
- Check mode: `out_par = in_par` and `out_err = raw ^ in_par ^ odd_sel`.
  - Even parity: an error is flagged when the XOR of data and parity bit is 1.
  - Odd parity: an error is flagged when that XOR is 0.
- Frame accumulator `facc` (1 bit, internal) updates only on accepted beats:
  - on a non-last beat, `facc <= facc ^ raw`;
  - on a last beat, `facc <= 0`.
- On a last beat the registered `out_frame_par = facc ^ raw ^ odd_sel`, i.e. the parity over every data bit of the frame. A single-beat frame gives `raw ^ odd_sel`.
- `mode` and `odd_sel` changing mid-frame is legal. Each beat uses its own sampled values. Frame parity uses `odd_sel` as sampled on the last beat.
- Error counter:
  - increments by 1 on each accepted beat in check mode with `out_err` computed as 1;
  - saturates at all-ones;
  - `cnt_clr` has priority over an increment in the same cycle, giving a result of 0.

## Timing
- Single output register stage. Latency is 1 cycle from accept to `out_valid`.
- `in_ready = !out_valid || out_ready`, so sustained throughput is 1 beat per cycle with no bubbles. `in_ready` is combinational from `out_ready`.
- The output register loads on `acc`. `out_valid` clears when `out_valid && out_ready && !acc`.
- While `out_valid && !out_ready`, every `out_*` signal is held stable. `in_ready` is 0 in this state.
- Reset values: `out_valid`, `out_data`, `out_par`, `out_err`, `out_last`, `out_frame_par`, `facc` and `err_cnt` are all 0. `in_ready` is 1 while out of reset.
- Reset asserted mid-frame discards the partial frame and the beat held in the output register. The first beat after reset starts a new frame.
- `err_cnt` updates on the same edge that loads the erroneous beat into the output register. It is therefore visible in the same cycle as `out_err`.

## Configuration
- `PARITY_ERR_CNT_EN` defined: the error counter and the `err_cnt` port are compiled in. `cnt_clr` behaves as described above.
- Not defined: no counter logic and no `err_cnt` port. `cnt_clr` is still present but ignored. All other behaviour is identical.

## Test plan
- Generate mode, even parity, `DATA_W=8`, beat 0xA5 with `out_ready=1` → next cycle `out_valid=1`, `out_data=0xA5`, `out_par=0`. With `odd_sel=1` → `out_par=1`.
- Check mode, even parity, data 0x01 with `in_par=0` → `out_err=1`, `err_cnt` goes from 0 to 1. Data 0x01 with `in_par=1` → `out_err=0`, count unchanged.
- 3-beat frame 0x01, 0x03, 0x07 with `in_last` on the third beat, even parity → `out_frame_par=0` on the last output beat (6 ones in total). The next single-beat frame 0x80 → `out_frame_par=1`.
- Back-pressure: hold `out_ready=0` for 4 cycles with `in_valid=1` → `in_ready=0`, outputs held stable, no beat lost or duplicated. The stream resumes 1 beat per cycle after release.
- With `CNT_W=2`, 5 consecutive error beats → `err_cnt` goes 1, 2, 3, 3, 3. `cnt_clr` asserted in the same cycle as an error beat → `err_cnt=0`.
- Assert `rst_n` low after beat 2 of a 3-beat frame, then release → all outputs are 0. A new frame 0xFF (last) → `out_frame_par=0`, unaffected by the pre-reset beats.
